multicycle_mips: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS top level.
- Each instruction runs through a FETCH/DECODE/EXEC/MEM/WB state machine, so one ALU and the register file are reused across cycles.
- Instruction memory is loaded through an external write port; data memory is internal.
- Adds a halt instruction, sign-extended word-addressed branches, jump, and addi, which the single-cycle design lacks.

---
 rtl/multicycle_mips.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_mips.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB/HALT sharing one ALU and register file.
// Optional feature macro: MIPS_PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
module multicycle_mips #(
   parameter int XLEN  = 32,
   parameter int IM_AW = 8,
   parameter int DM_AW = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             im_write,
   input  logic [31:0]      im_addr,
   input  logic [31:0]      im_wdata,
   output logic [IM_AW-1:0] pc_out,
   output logic [2:0]       state_out,
   output logic             retire,
   output logic             halted
`ifdef MIPS_PERF_CNT_EN
   ,
   output logic [31:0]      cycle_cnt,
   output logic [31:0]      instr_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

   state_t            state, state_next;
   logic [IM_AW-1:0]  pc, pc_target;
   logic              pc_load;
   logic [31:0]       ir;
   logic [XLEN-1:0]   a, b, alu_out, mdr;
   logic [XLEN-1:0]   alu_b, alu_y, imm_sext, rf_wdata;
   logic              insn_ok, rf_we, dm_we, retire_next;
   logic [4:0]        rf_waddr;
   logic [5:0]        op, funct;
   logic [4:0]        rs, rt, rd;
   logic [DM_AW-1:0]  dm_addr;

   logic [31:0]       imem [2**IM_AW];
   logic [XLEN-1:0]   dmem [2**DM_AW];
   logic [XLEN-1:0]   rf   [32];

   logic              unused_addr_bits;
   assign unused_addr_bits = ^im_addr[31:IM_AW];

   assign op       = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign funct    = ir[5:0];
   assign imm_sext = XLEN'($signed(ir[15:0]));
   assign dm_addr  = alu_out[DM_AW-1:0];

   assign pc_out    = pc;
   assign state_out = state;
   assign halted    = (state == S_HALT);

   // ALU and instruction legality; loads, stores and addi all reduce to rs + sext(imm).
   always_comb begin
      // NOTE: every variable gets a default first so no path through the block infers a latch.
      alu_b   = (op == OP_RTYPE) ? b : imm_sext;
      alu_y   = a + alu_b;
      insn_ok = 1'b1;
      if (op == OP_RTYPE) begin
         case (funct)
            FN_ADD:  alu_y = a + b;
            FN_SUB:  alu_y = a - b;
            FN_AND:  alu_y = a & b;
            FN_OR:   alu_y = a | b;
            FN_SLT:  alu_y = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
            default: insn_ok = 1'b0;
         endcase
      end else if (!(op inside {OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT})) begin
         insn_ok = 1'b0;
      end
   end

   always_comb begin
      state_next  = state;
      pc_load     = 1'b0;
      pc_target   = pc;
      rf_we       = 1'b0;
      rf_waddr    = rt;
      rf_wdata    = alu_out;
      dm_we       = 1'b0;
      retire_next = 1'b0;
      case (state)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: state_next = (op == OP_HALT) ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (!insn_ok) begin
               retire_next = 1'b1;
               state_next  = S_FETCH;
            end else begin
               case (op)
                  OP_RTYPE, OP_ADDI: state_next = S_WB;
                  OP_LW, OP_SW:      state_next = S_MEM;
                  OP_BEQ: begin
                     // pc already points at the next word, so this is pc+1+sext(imm)
                     pc_load     = (a == b);
                     pc_target   = pc + IM_AW'(imm_sext);
                     retire_next = 1'b1;
                     state_next  = S_FETCH;
                  end
                  OP_J: begin
                     pc_load     = 1'b1;
                     pc_target   = ir[IM_AW-1:0];
                     retire_next = 1'b1;
                     state_next  = S_FETCH;
                  end
                  default: begin
                     retire_next = 1'b1;
                     state_next  = S_FETCH;
                  end
               endcase
            end
         end
         S_MEM: begin
            if (op == OP_SW) begin
               dm_we       = 1'b1;
               retire_next = 1'b1;
               state_next  = S_FETCH;
            end else begin
               state_next = S_WB;
            end
         end
         S_WB: begin
            rf_we       = 1'b1;
            rf_waddr    = (op == OP_RTYPE) ? rd : rt;
            rf_wdata    = (op == OP_LW) ? mdr : alu_out;
            retire_next = 1'b1;
            state_next  = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state   <= S_FETCH;
         pc      <= '0;
         ir      <= '0;
         retire  <= 1'b0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
      end else begin
         state  <= state_next;
         retire <= retire_next;
         if (state == S_FETCH) begin
            ir <= imem[pc];
            pc <= pc + 1'b1;
         end
         if (pc_load)
            pc <= pc_target;
         if (state == S_DECODE) begin
            a <= rf[rs];
            b <= rf[rt];
         end
         if (state == S_EXEC)
            alu_out <= alu_y;
         if (state == S_MEM)
            mdr <= dmem[dm_addr];
      end
   end

   // Register file is cleared by reset; R0 is never written so it always reads 0.
   always_ff @(posedge clk) begin
      if (rstn) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= '0;
      end else if (rf_we && rf_waddr != 5'd0) begin
         rf[rf_waddr] <= rf_wdata;
      end
   end

   // NOTE: the memories carry no reset so they map onto RAM; contents survive a core reset.
   always_ff @(posedge clk) begin
      if (im_write)
         imem[im_addr[IM_AW-1:0]] <= im_wdata;
   end

   always_ff @(posedge clk) begin
      if (dm_we && !rstn)
         dmem[dm_addr] <= b;
   end

`ifdef MIPS_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rstn) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (state != S_HALT)
            cycle_cnt <= cycle_cnt + 32'd1;
         if (retire_next)
            instr_cnt <= instr_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_mips.sv
// Self-checking bench for multicycle_mips: directed vector table, multi-cycle corner
// sequences and a randomized program checked against an instruction-level model.
module tb_multicycle_mips;
   localparam int XLEN  = 32;
   localparam int IM_AW = 8;
   localparam int DM_AW = 8;

   localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

   logic             clk = 1'b0;
   logic             rstn = 1'b1;
   logic             im_write = 1'b0;
   logic [31:0]      im_addr = '0;
   logic [31:0]      im_wdata = '0;
   logic [IM_AW-1:0] pc_out;
   logic [2:0]       state_out;
   logic             retire;
   logic             halted;
`ifdef MIPS_PERF_CNT_EN
   logic [31:0]      cycle_cnt;
   logic [31:0]      instr_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Instruction-level reference model state
   logic [31:0] m_imem [256];
   logic [31:0] m_dmem [256];
   logic [31:0] m_regs [32];
   logic [7:0]  m_pc;

   typedef struct {
      int          addr;
      logic [31:0] instr;
      int          lat;
      int          pc;
      int          wreg;
      logic [31:0] wval;
   } vec_t;

   multicycle_mips #(.XLEN(XLEN), .IM_AW(IM_AW), .DM_AW(DM_AW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .im_write  (im_write),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .pc_out    (pc_out),
      .state_out (state_out),
      .retire    (retire),
      .halted    (halted)
`ifdef MIPS_PERF_CNT_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(input int tgt);
      return {OP_J, 26'(tgt)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_reset();
      rstn = 1'b1;
      tick();
   endtask

   task automatic load(input int addr, input logic [31:0] w);
      im_write = 1'b1;
      im_addr  = 32'(addr);
      im_wdata = w;
      m_imem[addr % 256] = w;
      tick();
      im_write = 1'b0;
   endtask

   task automatic release_reset();
      tick();
      rstn = 1'b0;
      m_pc = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
   endtask

   // Counts clock edges until retire is seen, bounded so a stuck core cannot hang the run.
   task automatic wait_retire(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!retire && lat < 12);
   endtask

   // Executes one instruction of the model; returns latency and written register (-1 if none).
   task automatic model_step(output int lat, output int wreg);
      logic [31:0] ins, ra, rb, simm, v;
      logic [5:0]  op, fn;
      logic [7:0]  npc;
      int          rs, rt, rd;
      ins  = m_imem[m_pc];
      op   = ins[31:26];
      fn   = ins[5:0];
      rs   = int'(ins[25:21]);
      rt   = int'(ins[20:16]);
      rd   = int'(ins[15:11]);
      ra   = m_regs[rs];
      rb   = m_regs[rt];
      simm = {{16{ins[15]}}, ins[15:0]};
      npc  = m_pc + 8'd1;
      lat  = 3;
      wreg = -1;
      v    = '0;
      case (op)
         6'h00: begin
            lat  = 4;
            wreg = rd;
            case (fn)
               FN_ADD:  v = ra + rb;
               FN_SUB:  v = ra - rb;
               FN_AND:  v = ra & rb;
               FN_OR:   v = ra | rb;
               FN_SLT:  v = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
               default: begin lat = 3; wreg = -1; end
            endcase
         end
         OP_ADDI: begin lat = 4; wreg = rt; v = ra + simm; end
         OP_LW:   begin lat = 5; wreg = rt; v = m_dmem[8'(ra + simm)]; end
         OP_SW:   begin lat = 4; m_dmem[8'(ra + simm)] = rb; end
         OP_BEQ:  if (ra == rb) npc = m_pc + 8'd1 + simm[7:0];
         OP_J:    npc = ins[7:0];
         default: ;
      endcase
      if (wreg > 0) m_regs[wreg] = v;
      m_pc = npc;
   endtask

   function automatic logic [31:0] rand_instr();
      int k, rs, rt, rd;
      logic [5:0] fn;
      k  = int'($urandom_range(0, 9));
      rs = int'($urandom_range(0, 7));
      rt = int'($urandom_range(0, 7));
      rd = int'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
         0:       fn = FN_ADD;
         1:       fn = FN_SUB;
         2:       fn = FN_AND;
         3:       fn = FN_OR;
         default: fn = FN_SLT;
      endcase
      case (k)
         0, 1:    return enc_r(rs, rt, rd, fn);
         2:       return enc_r(rs, rt, rd, 6'h21);
         3, 4:    return enc_i(OP_ADDI, rs, rt, int'($urandom_range(0, 65535)));
         5:       return enc_i(OP_LW, 0, rt, int'($urandom_range(0, 15)));
         6:       return enc_i(OP_SW, 0, rt, int'($urandom_range(0, 15)));
         7:       return enc_i(OP_BEQ, rs % 3, rt % 3, int'($urandom_range(0, 16)) - 8);
         8:       return enc_j(int'($urandom_range(16, 255)));
         default: return enc_i(6'h01, rs, rt, 0);
      endcase
   endfunction

   initial begin
      vec_t tab[$];
      int   lat, wreg;

      // Reset state
      begin_reset();
      tick();
      release_reset();
      check("reset_pc", pc_out, 0);
      check("reset_state", state_out, 0);
      check("reset_halted", halted, 0);
      check("reset_retire", retire, 0);

      // addi/addi/add/halt: retire at cycles 4, 8, 12; halted from cycle 14 onward
      begin_reset();
      load(0, enc_i(OP_ADDI, 0, 1, 5));
      load(1, enc_i(OP_ADDI, 0, 2, -3));
      load(2, enc_r(1, 2, 3, FN_ADD));
      load(3, {OP_HALT, 26'd0});
      release_reset();
      for (int c = 1; c <= 20; c++) begin
         tick();
         check($sformatf("retire_c%0d", c), retire, (c == 4 || c == 8 || c == 12));
         check($sformatf("halted_c%0d", c), halted, (c >= 14));
      end
      check("plan_r3", dut.rf[3], 32'd2);
      check("plan_pc_frozen", pc_out, 4);

      // Directed vector table: {addr, instr, latency, pc after, written reg, value}
      tab.push_back('{0,  enc_i(OP_ADDI, 0, 1, 5),     4, 1,  1,  32'd5});
      tab.push_back('{1,  enc_i(OP_ADDI, 0, 2, -3),    4, 2,  2,  32'hFFFF_FFFD});
      tab.push_back('{2,  enc_r(1, 2, 3, FN_ADD),      4, 3,  3,  32'd2});
      tab.push_back('{3,  enc_r(1, 2, 4, FN_SUB),      4, 4,  4,  32'd8});
      tab.push_back('{4,  enc_r(2, 1, 5, FN_SLT),      4, 5,  5,  32'd1});
      tab.push_back('{5,  enc_r(1, 2, 6, FN_AND),      4, 6,  6,  32'd5});
      tab.push_back('{6,  enc_r(1, 2, 7, FN_OR),       4, 7,  7,  32'hFFFF_FFFD});
      tab.push_back('{7,  enc_i(OP_SW, 0, 3, 7),       4, 8,  -1, 32'd0});
      tab.push_back('{8,  enc_i(OP_LW, 0, 8, 7),       5, 9,  8,  32'd2});
      tab.push_back('{9,  enc_i(OP_BEQ, 8, 3, 2),      3, 12, -1, 32'd0});
      tab.push_back('{12, enc_i(OP_BEQ, 1, 2, 5),      3, 13, -1, 32'd0});
      tab.push_back('{13, enc_r(1, 2, 9, 6'h21),       3, 14, 9,  32'd0});
      tab.push_back('{14, enc_i(6'h10, 1, 2, 0),       3, 15, -1, 32'd0});
      tab.push_back('{15, enc_j(40),                   3, 40, -1, 32'd0});
      tab.push_back('{40, enc_i(OP_ADDI, 1, 10, -6),   4, 41, 10, 32'hFFFF_FFFF});
      tab.push_back('{41, enc_r(10, 0, 11, FN_SLT),    4, 42, 11, 32'd1});
      tab.push_back('{42, enc_i(OP_SW, 3, 10, -3),     4, 43, -1, 32'd0});
      tab.push_back('{43, enc_i(OP_LW, 0, 12, 255),    5, 44, 12, 32'hFFFF_FFFF});
      tab.push_back('{44, enc_r(1, 1, 0, FN_ADD),      4, 45, 0,  32'd0});
      begin_reset();
      foreach (tab[i]) load(tab[i].addr, tab[i].instr);
      load(45, {OP_HALT, 26'd0});
      release_reset();
      foreach (tab[i]) begin
         wait_retire(lat);
         check($sformatf("vec%0d_latency", i), lat, tab[i].lat);
         check($sformatf("vec%0d_pc", i), pc_out, tab[i].pc);
         if (tab[i].wreg >= 0)
            check($sformatf("vec%0d_r%0d", i, tab[i].wreg), dut.rf[tab[i].wreg], tab[i].wval);
      end
      tick();
      tick();
      check("vec_halted", halted, 1);
      check("vec_halt_state", state_out, 5);
      repeat (5) tick();
      check("vec_halt_sticky", halted, 1);
      check("vec_halt_pc", pc_out, 46);

      // PC wrap: branch from the last word with +1 lands on 1, then j 0
      begin_reset();
      load(0, enc_j(255));
      load(255, enc_i(OP_BEQ, 0, 0, 1));
      load(1, enc_j(0));
      release_reset();
      wait_retire(lat);
      check("wrap_j_pc", pc_out, 255);
      wait_retire(lat);
      check("wrap_beq_lat", lat, 3);
      check("wrap_beq_pc", pc_out, 1);
      wait_retire(lat);
      check("wrap_j0_pc", pc_out, 0);

      // beq r0,r0,-1 spins on the same word every 3 cycles
      begin_reset();
      load(0, enc_i(OP_BEQ, 0, 0, -1));
      release_reset();
      for (int k = 0; k < 3; k++) begin
         wait_retire(lat);
         check($sformatf("spin%0d_lat", k), lat, 3);
         check($sformatf("spin%0d_pc", k), pc_out, 0);
      end

      // Reset during the MEM cycle of a store suppresses that store only
      begin_reset();
      load(0, enc_i(OP_ADDI, 0, 1, 32'h55));
      load(1, enc_i(OP_SW, 0, 1, 3));
      load(2, {OP_HALT, 26'd0});
      release_reset();
      wait_retire(lat);
      wait_retire(lat);
      check("abort_pre_store", dut.dmem[3], 32'h55);
      begin_reset();
      load(0, enc_i(OP_ADDI, 0, 1, 32'h66));
      release_reset();
      wait_retire(lat);
      check("abort_addi_r1", dut.rf[1], 32'h66);
      repeat (3) tick();
      check("abort_in_mem", state_out, 3);
      rstn = 1'b1;
      tick();
      check("abort_store_dropped", dut.dmem[3], 32'h55);
      check("abort_state", state_out, 0);
      check("abort_pc", pc_out, 0);
      check("abort_retire", retire, 0);
      check("abort_rf_cleared", dut.rf[1], 32'd0);

`ifdef MIPS_PERF_CNT_EN
      begin_reset();
      for (int k = 0; k < 4; k++) load(k, enc_i(OP_ADDI, 0, k + 1, k + 1));
      load(4, {OP_HALT, 26'd0});
      release_reset();
      repeat (22) tick();
      check("perf_instr_cnt", instr_cnt, 32'd4);
      check("perf_cycle_cnt", cycle_cnt, 32'd18);
      repeat (10) tick();
      check("perf_instr_frozen", instr_cnt, 32'd4);
      check("perf_cycle_frozen", cycle_cnt, 32'd18);
`endif

      // Randomized program: prologue zeroes dmem[0..15], random code fills the rest
      begin_reset();
      for (int k = 0; k < 16; k++) load(k, enc_i(OP_SW, 0, 0, k));
      for (int k = 16; k < 256; k++) load(k, rand_instr());
      release_reset();
      for (int s = 0; s < 220; s++) begin
         model_step(lat, wreg);
         begin
            int dut_lat;
            wait_retire(dut_lat);
            check($sformatf("rnd%0d_latency", s), dut_lat, lat);
         end
         check($sformatf("rnd%0d_pc", s), pc_out, m_pc);
         if (wreg >= 0)
            check($sformatf("rnd%0d_r%0d", s, wreg), dut.rf[wreg], m_regs[wreg]);
      end
      for (int r = 0; r < 8; r++)
         check($sformatf("rnd_final_r%0d", r), dut.rf[r], m_regs[r]);
      for (int d = 0; d < 16; d++)
         check($sformatf("rnd_final_dmem%0d", d), dut.dmem[d], m_dmem[d]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
